// File: rtl/rotl_seq_unit.sv
// Sequential rotate-left functional unit: rotates A left by (B mod WIDTH),
// one bit position per clock, with a start/busy/done handshake.
module rotl_seq_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_work_rot;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_next;
    logic [SHW-1:0]   r_cnt;
    logic [SHW-1:0]   w_cnt_next;
    logic [SHW-1:0]   w_amount;
    logic             w_unused_b;

    // Only the low SHW bits of B matter: the amount wraps modulo WIDTH.
    assign w_amount   = B[SHW-1:0];
    assign w_unused_b = ^B[WIDTH-1:SHW];

    // One-position left rotation of the working register.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign w_work_rot[gi] = r_work[(gi + WIDTH - 1) % WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_work   <= w_work_next;
            r_cnt    <= w_cnt_next;
            r_result <= w_result_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_work_next   = r_work;
        w_cnt_next    = r_cnt;
        w_result_next = r_result;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_work_next = A;
                    w_cnt_next  = w_amount;
                    // A zero amount skips RUN and completes on the next cycle.
                    if (w_amount == '0) begin
                        w_result_next = A;
                        w_state_next  = S_DONE;
                    end else begin
                        w_state_next  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_work_next = w_work_rot;
                w_cnt_next  = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_result_next = w_work_rot;
                    w_state_next  = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign R    = r_result;

endmodule
